// File: rtl/data_memory_responder_if.sv
// CPU <-> data-memory handshake bundle: request/address/data from the cpu,
// load data and busywait stall back from the memory responder.
interface data_memory_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              busywait;

  modport master (
    output read, write, address, writedata,
    input  readdata, busywait
  );

  modport slave (
    input  read, write, address, writedata,
    output readdata, busywait
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data-memory responder: stalls every accepted request for LATENCY+1 edges, then
// completes it. Optional access counters via macro DMEM_ACCESS_STATS_EN.
module data_memory_responder #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LATENCY = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  data_memory_responder_if.slave  mem_bus
`ifdef DMEM_ACCESS_STATS_EN
  ,
  output logic [15:0]             o_rd_count,
  output logic [15:0]             o_wr_count
`endif
);

  localparam int         DEPTH    = 2 ** ADDR_W;
  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic              w_valid_req;
  logic              w_accept;
  logic              w_complete;
  logic              w_busywait;
  logic [7:0]        r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              r_op_write;
  logic [DATA_W-1:0] r_readdata;
  logic [DATA_W-1:0] r_mem [DEPTH];

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and stall decode; DONE deliberately ignores a still-held request
  always_comb begin
    w_state_next = r_state;
    w_busywait   = 1'b0;
    w_accept     = 1'b0;
    w_complete   = 1'b0;
    w_valid_req  = mem_bus.read ^ mem_bus.write;
    case (r_state)
      IDLE: begin
        w_busywait = w_valid_req;
        if (w_valid_req) begin
          w_accept     = 1'b1;
          w_state_next = ACCESS;
        end else begin
          w_state_next = IDLE;
        end
      end
      ACCESS: begin
        w_busywait = 1'b1;
        if (r_cnt == 8'd0) begin
          w_complete   = 1'b1;
          w_state_next = DONE;
        end else begin
          w_state_next = ACCESS;
        end
      end
      DONE: begin
        w_busywait   = 1'b0;
        w_state_next = IDLE;
      end
      default: begin
        w_busywait   = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  // Stall is forced low while reset is asserted so an aborted access releases at once
  assign mem_bus.busywait = w_busywait & ~i_rst;
  assign mem_bus.readdata = r_readdata;

  // Request latch, latency counter and load data
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt      <= 8'd0;
      r_addr     <= '0;
      r_data     <= '0;
      r_op_write <= 1'b0;
      r_readdata <= '0;
    end else begin
      if (w_accept) begin
        r_addr     <= mem_bus.address;
        r_data     <= mem_bus.writedata;
        r_op_write <= mem_bus.write;
        r_cnt      <= CNT_INIT;
      end else if ((r_state == ACCESS) && (r_cnt != 8'd0)) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_complete && !r_op_write) begin
        r_readdata <= r_mem[r_addr];
      end
    end
  end

  // Storage array, fully cleared by reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_complete && r_op_write) begin
        r_mem[r_addr] <= r_data;
      end
    end
  end

`ifdef DMEM_ACCESS_STATS_EN
  logic [15:0] r_rd_count;
  logic [15:0] r_wr_count;

  // Saturating completion counters
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_count <= 16'd0;
      r_wr_count <= 16'd0;
    end else begin
      if (w_complete && !r_op_write && (r_rd_count != 16'hFFFF)) begin
        r_rd_count <= r_rd_count + 16'd1;
      end
      if (w_complete && r_op_write && (r_wr_count != 16'hFFFF)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  assign o_rd_count = r_rd_count;
  assign o_wr_count = r_wr_count;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: one DUT at LATENCY=5, one at LATENCY=1.
module tb_data_memory_responder;

  logic clk;
  logic rst;
  int   vecs;
  int   errs;
  int   edges;

  data_memory_responder_if #(.ADDR_W(8), .DATA_W(8)) bus5 ();
  data_memory_responder_if #(.ADDR_W(8), .DATA_W(8)) bus1 ();

`ifdef DMEM_ACCESS_STATS_EN
  logic [15:0] rd5, wr5, rd1, wr1;
`endif

  data_memory_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(5)) u_dut5 (
    .i_clk   (clk),
    .i_rst   (rst),
    .mem_bus (bus5)
`ifdef DMEM_ACCESS_STATS_EN
    ,
    .o_rd_count (rd5),
    .o_wr_count (wr5)
`endif
  );

  data_memory_responder #(.ADDR_W(8), .DATA_W(8), .LATENCY(1)) u_dut1 (
    .i_clk   (clk),
    .i_rst   (rst),
    .mem_bus (bus1)
`ifdef DMEM_ACCESS_STATS_EN
    ,
    .o_rd_count (rd1),
    .o_wr_count (wr1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic rd, input logic wr,
                       input logic [7:0] a, input logic [7:0] d);
    if (sel == 5) begin
      bus5.read = rd; bus5.write = wr; bus5.address = a; bus5.writedata = d;
    end else begin
      bus1.read = rd; bus1.write = wr; bus1.address = a; bus1.writedata = d;
    end
  endtask

  function automatic logic bw(input int sel);
    return (sel == 5) ? bus5.busywait : bus1.busywait;
  endfunction

  function automatic logic [7:0] rdata(input int sel);
    return (sel == 5) ? bus5.readdata : bus1.readdata;
  endfunction

  // Issue a request at a negedge, count rising edges while stalled; returns at the DONE negedge
  task automatic req(input int sel, input logic rd, input logic wr, input logic [7:0] a,
                     input logic [7:0] d, input bit hold, output int n);
    @(negedge clk);
    drive(sel, rd, wr, a, d);
    #1;
    chk("busywait_on_request", 32'(bw(sel)), 32'd1);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (bw(sel) === 1'b1 && n < 300);
    if (!hold) drive(sel, 1'b0, 1'b0, a, d);
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    rst  = 1'b1;
    drive(5, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busywait5", 32'(bus5.busywait), 32'd0);
    chk("reset_readdata5", 32'(bus5.readdata), 32'h00);
    chk("reset_busywait1", 32'(bus1.busywait), 32'd0);
    chk("reset_readdata1", 32'(bus1.readdata), 32'h00);
    rst = 1'b0;

    // write then read back, LATENCY=5
    req(5, 1'b0, 1'b1, 8'h10, 8'hA5, 1'b0, edges);
    chk("write10_stall_edges", 32'(edges), 32'd6);
    chk("write_keeps_readdata", 32'(bus5.readdata), 32'h00);
    req(5, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, edges);
    chk("read10_stall_edges", 32'(edges), 32'd6);
    chk("read10_data", 32'(bus5.readdata), 32'hA5);

    // illegal READ&WRITE is ignored
    @(negedge clk);
    drive(5, 1'b1, 1'b1, 8'h20, 8'h3C);
    #1;
    chk("illegal_busywait_now", 32'(bus5.busywait), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("illegal_busywait_held", 32'(bus5.busywait), 32'd0);
    end
    drive(5, 1'b0, 1'b0, 8'h20, 8'h3C);
    chk("illegal_readdata_kept", 32'(bus5.readdata), 32'hA5);
    req(5, 1'b1, 1'b0, 8'h20, 8'h00, 1'b0, edges);
    chk("read20_after_illegal", 32'(bus5.readdata), 32'h00);

    // address/data/op changes during ACCESS are ignored
    @(negedge clk);
    drive(5, 1'b0, 1'b1, 8'h01, 8'h77);
    @(posedge clk);
    @(negedge clk);
    drive(5, 1'b1, 1'b1, 8'h02, 8'h99);
    edges = 1;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
    end while (bus5.busywait === 1'b1 && edges < 300);
    drive(5, 1'b0, 1'b0, 8'h02, 8'h99);
    chk("midchange_stall_edges", 32'(edges), 32'd6);
    req(5, 1'b1, 1'b0, 8'h01, 8'h00, 1'b0, edges);
    chk("read01_latched_write", 32'(bus5.readdata), 32'h77);
    req(5, 1'b1, 1'b0, 8'h02, 8'h00, 1'b0, edges);
    chk("read02_untouched", 32'(bus5.readdata), 32'h00);

    // stale READ held into DONE must not be re-accepted
    req(5, 1'b1, 1'b0, 8'h01, 8'h00, 1'b1, edges);
    chk("stale_first_data", 32'(bus5.readdata), 32'h77);
    chk("stale_done_busywait", 32'(bus5.busywait), 32'd0);
    @(posedge clk);
    #1;
    drive(5, 1'b0, 1'b0, 8'h01, 8'h00);
    @(negedge clk);
    chk("stale_idle_busywait_a", 32'(bus5.busywait), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("stale_idle_busywait_b", 32'(bus5.busywait), 32'd0);
    req(5, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, edges);
    chk("fresh_read_edges", 32'(edges), 32'd6);
    chk("fresh_read_data", 32'(bus5.readdata), 32'hA5);

    // reset two cycles into a write aborts it and clears memory
    @(negedge clk);
    drive(5, 1'b0, 1'b1, 8'h05, 8'hFF);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy_before", 32'(bus5.busywait), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_busywait", 32'(bus5.busywait), 32'd0);
    chk("abort_readdata", 32'(bus5.readdata), 32'h00);
    @(negedge clk);
    drive(5, 1'b0, 1'b0, 8'h05, 8'h00);
    rst = 1'b0;
    req(5, 1'b1, 1'b0, 8'h05, 8'h00, 1'b0, edges);
    chk("abort_read05_edges", 32'(edges), 32'd6);
    chk("abort_read05_data", 32'(bus5.readdata), 32'h00);
    req(5, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, edges);
    chk("abort_mem_cleared", 32'(bus5.readdata), 32'h00);

    // LATENCY=1: 3 writes, 2 reads, 1 illegal
    req(1, 1'b0, 1'b1, 8'h03, 8'h11, 1'b0, edges);
    chk("lat1_write_edges", 32'(edges), 32'd2);
    req(1, 1'b0, 1'b1, 8'h04, 8'h22, 1'b0, edges);
    req(1, 1'b0, 1'b1, 8'h05, 8'h33, 1'b0, edges);
    req(1, 1'b1, 1'b0, 8'h04, 8'h00, 1'b0, edges);
    chk("lat1_read_edges", 32'(edges), 32'd2);
    chk("lat1_read04", 32'(rdata(1)), 32'h22);
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 8'h03, 8'hEE);
    #1;
    chk("lat1_illegal_busywait", 32'(bw(1)), 32'd0);
    @(posedge clk);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 8'h03, 8'h00);
    req(1, 1'b1, 1'b0, 8'h03, 8'h00, 1'b0, edges);
    chk("lat1_read03", 32'(rdata(1)), 32'h11);

`ifdef DMEM_ACCESS_STATS_EN
    chk("stats_wr1", 32'(wr1), 32'd3);
    chk("stats_rd1", 32'(rd1), 32'd2);
    chk("stats_wr5", 32'(wr5), 32'd0);
    chk("stats_rd5", 32'(rd5), 32'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
